// File: rtl/abcd_vector_sequencer.sv
// Self-running sweep of a 4-input decoder: drives {a,b,c,d} through 0..15,
// captures {x,y} per vector into a 32-bit word and compares it with a golden signature.
module abcd_vector_sequencer #(
  parameter int unsigned STEP_CYCLES = 10,
  parameter logic [31:0] EXPECTED    = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        x,
  input  logic        y,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  output logic [3:0]  vec_idx,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        pass
);

  localparam logic [7:0] STEP_LAST = 8'(STEP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  vec_idx_q, vec_idx_d;
  logic [3:0]  abcd_q, abcd_d;
  logic [7:0]  step_q, step_d;
  logic [31:0] result_q, result_d;
  logic        pass_q, pass_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [31:0] sample_word;

  // Places the {x,y} pair of vector idx into its two-bit slot of the result word.
  function automatic logic [31:0] insert_pair(input logic [31:0] word,
                                              input logic [3:0]  idx,
                                              input logic [1:0]  pair);
    logic [31:0] w;
    w = word;
    w[{idx, 1'b0} +: 2] = pair;
    return w;
  endfunction

  assign sample_word = insert_pair(result_q, vec_idx_q, {x, y});

  always_comb begin
    state_d   = state_q;
    vec_idx_d = vec_idx_q;
    abcd_d    = abcd_q;
    step_d    = step_q;
    result_d  = result_q;
    pass_d    = pass_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        abcd_d = 4'h0;
        if (start) begin
          state_d   = RUN;
          vec_idx_d = 4'h0;
          step_d    = 8'h00;
          result_d  = 32'h0;
          pass_d    = 1'b0;
          busy_d    = 1'b1;
        end
      end
      RUN: begin
        // The response is sampled on the last step so x,y have settled for STEP_CYCLES-1 cycles.
        if (step_q == STEP_LAST) begin
          result_d = sample_word;
          step_d   = 8'h00;
          if (vec_idx_q != 4'hF) begin
            vec_idx_d = vec_idx_q + 4'h1;
            abcd_d    = vec_idx_q + 4'h1;
          end else begin
            state_d   = DONE;
            busy_d    = 1'b0;
            done_d    = 1'b1;
            pass_d    = (sample_word == EXPECTED);
            abcd_d    = 4'h0;
            vec_idx_d = 4'h0;
          end
        end else begin
          step_d = step_q + 8'h01;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      vec_idx_q <= 4'h0;
      abcd_q    <= 4'h0;
      step_q    <= 8'h00;
      result_q  <= 32'h0;
      pass_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      vec_idx_q <= vec_idx_d;
      abcd_q    <= abcd_d;
      step_q    <= step_d;
      result_q  <= result_d;
      pass_q    <= pass_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign {a, b, c, d} = abcd_q;
  assign vec_idx      = vec_idx_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign result       = result_q;
  assign pass         = pass_q;

endmodule

// File: tb/tb_abcd_vector_sequencer.sv
// Bench for abcd_vector_sequencer: two instances (4-cycle and 10-cycle steps) driven by
// table-based decoder models; expected signatures come straight from the decoder tables.
module tb_abcd_vector_sequencer;

  localparam logic [31:0] EXP0 = 32'hEEEE_4444;
  localparam logic [31:0] EXP1 = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start0 = 1'b0;
  logic start1 = 1'b0;

  // Decoder tables: bits [2v+1:2v] = {x,y} returned for vector v.
  logic [31:0] lut0 = 32'h0;
  logic [31:0] lut1 = 32'h0;

  logic a0, b0, c0, d0, busy0, done0, pass0;
  logic a1, b1, c1, d1, busy1, done1, pass1;
  logic [3:0]  vec0, vec1;
  logic [31:0] res0, res1;
  logic [1:0]  xy0, xy1;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  assign xy0 = lut0[{a0, b0, c0, d0, 1'b0} +: 2];
  assign xy1 = lut1[{a1, b1, c1, d1, 1'b0} +: 2];

  abcd_vector_sequencer #(.STEP_CYCLES(4), .EXPECTED(EXP0)) u0 (
    .clk(clk), .rst(rst), .start(start0), .x(xy0[1]), .y(xy0[0]),
    .a(a0), .b(b0), .c(c0), .d(d0), .vec_idx(vec0),
    .busy(busy0), .done(done0), .result(res0), .pass(pass0)
  );

  abcd_vector_sequencer #(.STEP_CYCLES(10), .EXPECTED(EXP1)) u1 (
    .clk(clk), .rst(rst), .start(start1), .x(xy1[1]), .y(xy1[0]),
    .a(a1), .b(b1), .c(c1), .d(d1), .vec_idx(vec1),
    .busy(busy1), .done(done1), .result(res1), .pass(pass1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [42:0] obs;
    rst = 1'b1; start0 = 1'b1; start1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      obs = {busy0, done0, pass0, a0, b0, c0, d0, vec0, res0};
      total++;
      if (obs !== 43'h0) begin
        bad++; $display("FAIL reset_u0 cycle %0d: got %h want 0", i, obs);
      end
      obs = {busy1, done1, pass1, a1, b1, c1, d1, vec1, res1};
      total++;
      if (obs !== 43'h0) begin
        bad++; $display("FAIL reset_u1 cycle %0d: got %h want 0", i, obs);
      end
    end
    rst = 1'b0; start0 = 1'b0; start1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      obs = {busy0, done0, pass0, a0, b0, c0, d0, vec0, res0};
      total++;
      if (obs !== 43'h0) begin
        bad++; $display("FAIL post_reset_u0 cycle %0d: got %h want 0", i, obs);
      end
      obs = {busy1, done1, pass1, a1, b1, c1, d1, vec1, res1};
      total++;
      if (obs !== 43'h0) begin
        bad++; $display("FAIL post_reset_u1 cycle %0d: got %h want 0", i, obs);
      end
    end
  endtask

  // Full sweep on u0 with a 1-cycle start pulse; optional random start noise while busy.
  task automatic sweep0(input logic [31:0] lut, input bit noisy, input string name);
    logic [9:0] obs, exp_v;
    int done_cnt;
    lut0 = lut;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    for (int k = 0; k < 64; k++) begin
      obs   = {busy0, done0, a0, b0, c0, d0, vec0};
      exp_v = {1'b1, 1'b0, 4'(k / 4), 4'(k / 4)};
      total++;
      if (obs !== exp_v) begin
        bad++; $display("FAIL %s run k=%0d: got %h want %h", name, k, obs, exp_v);
      end
      if (noisy) start0 = 1'($urandom_range(0, 1));
      tick();
    end
    start0 = 1'b0;
    obs   = {busy0, done0, a0, b0, c0, d0, vec0};
    exp_v = {1'b0, 1'b1, 8'h00};
    total++;
    if (obs !== exp_v) begin
      bad++; $display("FAIL %s done_state: got %h want %h", name, obs, exp_v);
    end
    total++;
    if (res0 !== lut) begin
      bad++; $display("FAIL %s result: got %h want %h", name, res0, lut);
    end
    total++;
    if (pass0 !== (lut == EXP0)) begin
      bad++; $display("FAIL %s pass: got %b want %b", name, pass0, (lut == EXP0));
    end
    done_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (done0 === 1'b1 || busy0 !== 1'b0 || {a0, b0, c0, d0} !== 4'h0) done_cnt++;
    end
    total++;
    if (done_cnt != 0) begin
      bad++; $display("FAIL %s idle_after: got %0d bad idle cycles want 0", name, done_cnt);
    end
    total++;
    if ({res0, pass0} !== {lut, (lut == EXP0)}) begin
      bad++; $display("FAIL %s hold: got %h/%b want %h/%b", name, res0, pass0, lut, (lut == EXP0));
    end
  endtask

  task automatic test_golden();
    sweep0(32'hEEEE_4444, 1'b0, "golden");
  endtask

  task automatic test_mismatch();
    sweep0(32'h0000_0000, 1'b0, "mismatch");
  endtask

  task automatic test_random_start_noise();
    for (int n = 0; n < 3; n++) sweep0($urandom, 1'b1, "random");
  endtask

  task automatic test_drive_timing();
    logic [9:0] obs, exp_v;
    lut1 = $urandom;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int k = 0; k < 160; k++) begin
      obs   = {busy1, done1, a1, b1, c1, d1, vec1};
      exp_v = {1'b1, 1'b0, 4'(k / 10), 4'(k / 10)};
      total++;
      if (obs !== exp_v) begin
        bad++; $display("FAIL drive k=%0d: got %h want %h", k, obs, exp_v);
      end
      tick();
    end
    obs   = {busy1, done1, a1, b1, c1, d1, vec1};
    exp_v = {1'b0, 1'b1, 8'h00};
    total++;
    if (obs !== exp_v) begin
      bad++; $display("FAIL drive_done: got %h want %h", obs, exp_v);
    end
    total++;
    if ({res1, pass1} !== {lut1, (lut1 == EXP1)}) begin
      bad++; $display("FAIL drive_result: got %h/%b want %h/%b", res1, pass1, lut1, (lut1 == EXP1));
    end
    tick();
    total++;
    if ({busy1, done1, a1, b1, c1, d1} !== 6'h0) begin
      bad++; $display("FAIL drive_idle: got %h want 0", {busy1, done1, a1, b1, c1, d1});
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] obs, exp_v;
    lut0 = $urandom;
    start0 = 1'b1;
    tick();
    for (int s = 0; s < 2; s++) begin
      for (int k = 0; k < 64; k++) begin
        obs   = {busy0, done0, a0, b0, c0, d0, vec0};
        exp_v = {1'b1, 1'b0, 4'(k / 4), 4'(k / 4)};
        total++;
        if (obs !== exp_v) begin
          bad++; $display("FAIL b2b s=%0d k=%0d: got %h want %h", s, k, obs, exp_v);
        end
        tick();
      end
      total++;
      if ({busy0, done0, res0} !== {1'b0, 1'b1, lut0}) begin
        bad++; $display("FAIL b2b_done s=%0d: got %b%b %h want 01 %h", s, busy0, done0, res0, lut0);
      end
      tick();
      total++;
      if ({busy0, done0} !== 2'b00) begin
        bad++; $display("FAIL b2b_idle s=%0d: got %b%b want 00", s, busy0, done0);
      end
      if (s == 1) start0 = 1'b0;
      tick();
    end
    total++;
    if (busy0 !== 1'b0) begin
      bad++; $display("FAIL b2b_stop: got busy %b want 0", busy0);
    end
  endtask

  task automatic test_mid_reset();
    int seen;
    lut0 = $urandom;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    for (int k = 0; k < 28; k++) tick();
    total++;
    if (vec0 !== 4'd7) begin
      bad++; $display("FAIL midrst_pos: got vec %0d want 7", vec0);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if ({busy0, done0, pass0, a0, b0, c0, d0, vec0, res0} !== 43'h0) begin
      bad++; $display("FAIL midrst_clear: got %h want 0",
                      {busy0, done0, pass0, a0, b0, c0, d0, vec0, res0});
    end
    seen = 0;
    for (int k = 0; k < 70; k++) begin
      tick();
      if (done0 !== 1'b0 || busy0 !== 1'b0) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++; $display("FAIL midrst_nodone: got %0d active cycles want 0", seen);
    end
    sweep0(32'hEEEE_4444, 1'b0, "after_rst");
  endtask

  initial begin
    test_reset();
    test_golden();
    test_mismatch();
    test_drive_timing();
    test_random_start_noise();
    test_back_to_back();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
